lcd_sequencer: RTL and testbench



---
 rtl/lcd_sequencer.sv | 152 +++++++++++++++
 tb/tb_lcd_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780 4-bit power-on init, byte writes over valid/ready, cursor tracking and line wrap
module lcd_sequencer #(
    parameter int PWRUP_CYC = 120000,
    parameter int SETUP_CYC = 1,
    parameter int E_CYC     = 4,
    parameter int CMD_CYC   = 400,
    parameter int CLR_CYC   = 40000,
    parameter int COLS      = 16
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic [3:0] lcd_dq,
    output logic       lcd_rs,
    output logic       lcd_e
);
    localparam int MAX_LR = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
    localparam int MAXC = (PWRUP_CYC > MAX_LR) ? PWRUP_CYC : MAX_LR;
    localparam int CW = $clog2(MAXC + SETUP_CYC + E_CYC + 1);
    localparam int CLW = $clog2(COLS + 1);
    localparam logic [CW-1:0] STB_END = CW'(SETUP_CYC + E_CYC);

    typedef enum logic [3:0] {
        PWRUP, INIT_NIB, INIT_WAIT, INIT_BYTE, IDLE, STROBE_HI, STROBE_LO, DELAY, WRAP
    } state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] step, step_n;
    logic [7:0] data_q, data_n;
    logic [CLW-1:0] col, col_n;
    logic [3:0] dq_n;
    logic rs_q, rs_n, line, line_n, done_n, clr, byte_end, stb_end, e_n, rsp_n;

    assign wr_ready = state == IDLE;
    assign clr = !rs_q && data_q[7:2] == 6'd0 && data_q[1:0] != 2'd0;
    assign byte_end = cnt == (clr ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1));
    assign stb_end = cnt == STB_END;

    always_ff @(posedge refclk or posedge reset)
        if (reset) begin
            state <= PWRUP;
            cnt <= '0;
            step <= '0;
            data_q <= '0;
            rs_q <= 1'b0;
            col <= '0;
            line <= 1'b0;
            init_done <= 1'b0;
            lcd_dq <= '0;
            lcd_rs <= 1'b0;
            lcd_e <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            step <= step_n;
            data_q <= data_n;
            rs_q <= rs_n;
            col <= col_n;
            line <= line_n;
            init_done <= done_n;
            lcd_dq <= dq_n;
            lcd_rs <= rsp_n;
            lcd_e <= e_n;
        end

    always_comb begin
        state_n = state;
        cnt_n = cnt + CW'(1);
        step_n = step;
        data_n = data_q;
        rs_n = rs_q;
        col_n = col;
        line_n = line;
        done_n = init_done;
        case (state)
            PWRUP: if (cnt == CW'(PWRUP_CYC - 1)) begin
                state_n = INIT_NIB;
                cnt_n = '0;
            end
            INIT_NIB: if (stb_end) begin
                state_n = INIT_WAIT;
                cnt_n = '0;
            end
            INIT_WAIT: if (cnt == (step == 3'd3 ? CW'(CMD_CYC - 1) : CW'(CLR_CYC - 1))) begin
                state_n = step == 3'd3 ? STROBE_HI : INIT_NIB;
                cnt_n = '0;
                step_n = step + 3'd1;
                data_n = 8'h28;
                rs_n = 1'b0;
            end
            INIT_BYTE: if (byte_end) begin
                state_n = step == 3'd7 ? IDLE : STROBE_HI;
                cnt_n = '0;
                step_n = step + 3'd1;
                done_n = step == 3'd7;
                data_n = step == 3'd4 ? 8'h0C : step == 3'd5 ? 8'h01 : 8'h06;
            end
            IDLE: begin
                cnt_n = '0;
                if (wr_valid) begin
                    state_n = STROBE_HI;
                    data_n = wr_data;
                    rs_n = wr_rs;
                    if (wr_rs)
                        col_n = col + CLW'(1);
                    else if (wr_data inside {8'h01, 8'h02, 8'h03}) begin
                        col_n = '0;
                        line_n = 1'b0;
                    end else if (wr_data[7]) begin
                        line_n = wr_data[6];
                        col_n = (32'(wr_data[3:0]) >= COLS) ? CLW'(COLS - 1) : CLW'(wr_data[3:0]);
                    end
                end
            end
            STROBE_HI: if (stb_end) begin
                state_n = STROBE_LO;
                cnt_n = '0;
            end
            STROBE_LO: if (stb_end) begin
                state_n = init_done ? DELAY : INIT_BYTE;
                cnt_n = '0;
            end
            DELAY: if (byte_end) begin
                state_n = (rs_q && col == CLW'(COLS)) ? WRAP : IDLE;
                cnt_n = '0;
            end
            WRAP: begin
                state_n = STROBE_HI;
                cnt_n = '0;
                data_n = line ? 8'h80 : 8'hC0;
                rs_n = 1'b0;
                line_n = ~line;
                col_n = '0;
            end
            default: state_n = PWRUP;
        endcase
    end

    // pins are registered from next-state values so E never glitches
    always_comb begin
        e_n = state_n inside {INIT_NIB, STROBE_HI, STROBE_LO} && cnt_n >= CW'(SETUP_CYC) && cnt_n < STB_END;
        dq_n = state_n == INIT_NIB ? (step_n == 3'd3 ? 4'h2 : 4'h3) :
               state_n == STROBE_HI ? data_n[7:4] :
               state_n == STROBE_LO ? data_n[3:0] : lcd_dq;
        rsp_n = state_n inside {STROBE_HI, STROBE_LO} ? rs_n : state_n == INIT_NIB ? 1'b0 : lcd_rs;
    end
endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: scoreboard bench; a rule-based model queues expected E pulses, a pin monitor checks them
module tb_lcd_sequencer;
    localparam int PW = 20, SU = 1, EC = 2, CMD = 5, CLR = 10, COLS = 4;
    localparam int NIB = 1 + SU + EC;
    localparam int INIT_T = PW + 3 * (NIB + CLR) + (NIB + CMD) + 4 * (2 * NIB) + 3 * CMD + CLR;

    typedef struct {
        bit rs;
        bit [3:0] dq;
        int gap;
    } pulse_t;

    logic clk = 1'b0, rst = 1'b1, wr_valid = 1'b0, wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic wr_ready, init_done, lcd_rs, lcd_e;
    logic [3:0] lcd_dq;
    int checks = 0, errors = 0, cyc = 0;
    int col = 0, line = 0;
    pulse_t exp_q[$];

    lcd_sequencer #(.PWRUP_CYC(PW), .SETUP_CYC(SU), .E_CYC(EC), .CMD_CYC(CMD), .CLR_CYC(CLR), .COLS(COLS)) dut (
        .refclk(clk), .reset(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rs(wr_rs),
        .wr_data(wr_data), .init_done(init_done), .lcd_dq(lcd_dq), .lcd_rs(lcd_rs), .lcd_e(lcd_e)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wait_of(bit rs, bit [7:0] d);
        return (!rs && d[7:2] == 6'd0 && d != 8'd0) ? CLR : CMD;
    endfunction

    task automatic push_unit(bit rs, bit [7:0] d, bit two, int gap);
        if (two) begin
            exp_q.push_back('{rs, d[7:4], gap});
            exp_q.push_back('{rs, d[3:0], NIB});
        end else
            exp_q.push_back('{rs, d[3:0], gap});
    endtask

    task automatic push_init();
        int g;
        bit [7:0] ib[4];
        ib = '{8'h28, 8'h0C, 8'h01, 8'h06};
        g = PW + SU;
        for (int i = 0; i < 3; i++) begin
            push_unit(1'b0, 8'h03, 1'b0, g);
            g = NIB + CLR;
        end
        push_unit(1'b0, 8'h02, 1'b0, g);
        g = NIB + CMD;
        for (int i = 0; i < 4; i++) begin
            push_unit(1'b0, ib[i], 1'b1, g);
            g = NIB + wait_of(1'b0, ib[i]);
        end
    endtask

    task automatic model_write(bit rs, bit [7:0] d, output int low);
        push_unit(rs, d, 1'b1, -1);
        if (rs) col++;
        else if (d >= 8'h01 && d <= 8'h03) begin
            col = 0;
            line = 0;
        end else if (d[7]) begin
            line = int'(d[6]);
            col = (int'(d[3:0]) >= COLS) ? COLS - 1 : int'(d[3:0]);
        end
        low = 2 * NIB + wait_of(rs, d);
        if (rs && col == COLS) begin
            push_unit(1'b0, line != 0 ? 8'h80 : 8'hC0, 1'b1, -1);
            line = 1 - line;
            col = 0;
            low = -1;
        end
    endtask

    task automatic wait_ready(int lim, output int n);
        n = 0;
        while (!wr_ready && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_low(int low);
        int n;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (low >= 0) chk("busy_cycles", n, low);
        else chk("wrap_busy_min", int'(n >= 2 * (2 * NIB + CMD) && wr_ready), 1);
    endtask

    task automatic do_write(bit rs, bit [7:0] d);
        int n, low;
        @(negedge clk);
        wait_ready(300, n);
        chk("ready_wait", int'(wr_ready), 1);
        model_write(rs, d, low);
        wr_valid = 1'b1;
        wr_rs = rs;
        wr_data = d;
        @(posedge clk);
        #1 wr_valid = 1'b0;
        wr_data = 8'($urandom_range(0, 255));
        count_low(low);
    endtask

    always @(negedge clk) begin : mon
        bit pe;
        int rise, last_rise;
        logic [3:0] cur_dq;
        logic cur_rs;
        pulse_t p;
        if (rst) begin
            pe = 1'b0;
            last_rise = 0;
        end else begin
            if (lcd_e && !pe) begin
                rise = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_unexpected: got dq=%0h rs=%0b at cycle %0d, expected no pulse", lcd_dq, lcd_rs, cyc);
                end else begin
                    p = exp_q.pop_front();
                    chk("pulse_rs", int'(lcd_rs), int'(p.rs));
                    chk("pulse_dq", int'(lcd_dq), int'(p.dq));
                    if (p.gap >= 0) chk("pulse_gap", cyc - last_rise, p.gap);
                end
                last_rise = cyc;
                cur_dq = lcd_dq;
                cur_rs = lcd_rs;
            end else if (pe) begin
                chk("dq_stable", int'(lcd_dq), int'(cur_dq));
                chk("rs_stable", int'(lcd_rs), int'(cur_rs));
                if (!lcd_e) chk("e_width", cyc - rise, EC);
            end
            pe = lcd_e;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, low;
        #12;
        chk("rst_e", int'(lcd_e), 0);
        chk("rst_dq", int'(lcd_dq), 0);
        chk("rst_rs", int'(lcd_rs), 0);
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_init_done", int'(init_done), 0);
        push_init();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_ready(400, n);
        chk("init_cycles", cyc, INIT_T);
        chk("init_done", int'(init_done), 1);

        do_write(1'b1, 8'h41);
        do_write(1'b0, 8'h01);
        for (int i = 0; i < 8; i++) do_write(1'b1, 8'(8'h30 + i));
        do_write(1'b0, 8'h85);
        do_write(1'b1, 8'h21);

        repeat (40) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_write(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        wait_ready(300, n);
        model_write(1'b1, 8'h5A, low);
        wr_valid = 1'b1;
        wr_rs = 1'b1;
        wr_data = 8'h5A;
        n = 0;
        @(negedge clk);
        while (!lcd_e && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("e_before_abort", int'(lcd_e), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_e", int'(lcd_e), 0);
        chk("abort_ready", int'(wr_ready), 0);
        chk("abort_init_done", int'(init_done), 0);
        exp_q.delete();
        col = 0;
        line = 0;
        push_init();
        model_write(1'b1, 8'h5A, low);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_ready(400, n);
        chk("reinit_cycles", cyc, INIT_T);
        chk("reinit_done", int'(init_done), 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        count_low(low);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
